multi_duration_timer: RTL and testbench

- Bank of NUM_CH independent duration timers for game-phase timing: attack startup/active/recovery, hit-stun, invulnerability windows and round timers.
- Each channel counts qualified ticks (a frame-rate enable) up to a limit supplied per channel at start time.
- Per-channel modes: one-shot, auto-reload and level-held.
- Supports pause, per-channel limit latching and a one-cycle done pulse.
- Sits between the player/game FSMs and the frame-tick generator.

---
 rtl/multi_duration_timer_pkg.sv | 21 ++
 rtl/multi_duration_timer_channel.sv | 100 ++++++++++
 rtl/multi_duration_timer.sv | 54 +++++
 tb/tb_multi_duration_timer.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/multi_duration_timer_pkg.sv
// Shared definitions for the multi-channel duration timer.
// Holds the mode encodings, the per-channel FSM state type, and a helper
// that folds the reserved mode code onto one-shot behaviour.
package multi_duration_timer_pkg;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;
  localparam logic [1:0] MODE_LEVEL   = 2'b10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Reserved code 2'b11 behaves exactly like one-shot, so it is normalised
  // at latch time and the rest of the channel only ever sees legal modes.
  function automatic logic [1:0] norm_mode(input logic [1:0] m);
    return (m == 2'b11) ? MODE_ONESHOT : m;
  endfunction

endpackage

// File: rtl/multi_duration_timer_channel.sv
// Single duration-timer channel: two-state FSM, latched limit/mode and an
// elapsed-tick counter.
// Ports:
//   clk, nRst         clock and synchronous active-high reset
//   tick              shared count-qualifying enable
//   start/stop/pause  per-channel control (start doubles as LEVEL hold)
//   mode, limit       sampled only when a start is accepted
//   busy              channel is in RUN
//   done              one-cycle completion pulse
//   count             elapsed ticks in the current period
module duration_channel
  import multi_duration_timer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             nRst,
  input  logic             tick,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] limit,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state;
  logic [WIDTH-1:0] lim_q;
  logic [1:0]       mode_q;

  logic advance;
  logic at_end;
  logic is_level;

  // lim_q is never 0 while in RUN, so limit-1 cannot underflow here.
  assign advance  = (state == ST_RUN) && tick && !pause;
  assign at_end   = (count == (lim_q - ONE));
  assign is_level = (mode_q == MODE_LEVEL);
  assign busy     = (state == ST_RUN);

  always_ff @(posedge clk) begin
    if (nRst) begin
      state  <= ST_IDLE;
      count  <= '0;
      lim_q  <= '0;
      mode_q <= MODE_ONESHOT;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (stop) begin
        // Abort wins over everything, including a same-cycle completion.
        state <= ST_IDLE;
        count <= '0;
      end else if (state == ST_IDLE) begin
        if (start) begin
          lim_q  <= limit;
          mode_q <= norm_mode(mode);
          count  <= '0;
          // A zero-length duration completes immediately without running.
          if (limit == '0) done  <= 1'b1;
          else             state <= ST_RUN;
        end
      end else begin
        if (is_level && !start) begin
          // Hold level dropped: silent abort.
          state <= ST_IDLE;
          count <= '0;
        end else begin
          if (advance) begin
            if (at_end) begin
              done  <= 1'b1;
              count <= '0;
              if (mode_q != MODE_RELOAD) state <= ST_IDLE;
            end else begin
              count <= count + ONE;
            end
          end
          // Restart overrides the completion's state/count update, while
          // the done pulse from that completion is kept.
          if (start && !is_level) begin
            lim_q  <= limit;
            mode_q <= norm_mode(mode);
            count  <= '0;
            if (limit == '0) begin
              done  <= 1'b1;
              state <= ST_IDLE;
            end else begin
              state <= ST_RUN;
            end
          end
        end
      end
    end
  end

endmodule

// File: rtl/multi_duration_timer.sv
// Bank of NUM_CH independent duration timers driven by a shared tick.
// Ports:
//   clk, nRst    clock and synchronous active-high reset
//   i_tick       shared count-qualifying enable
//   i_start      per-channel start/restart (LEVEL hold level)
//   i_stop       per-channel abort
//   i_pause      per-channel freeze
//   i_mode       2 bits per channel, channel k at [2k+1:2k]
//   i_limit      WIDTH bits per channel, channel k at [WIDTH*k +: WIDTH]
//   o_busy       per-channel RUN indicator
//   o_done       per-channel one-cycle completion pulse
//   o_count      per-channel elapsed-tick count
//   o_any_done   OR of o_done
module multi_duration_timer
  import multi_duration_timer_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 8
) (
  input  logic                    clk,
  input  logic                    nRst,
  input  logic                    i_tick,
  input  logic [NUM_CH-1:0]       i_start,
  input  logic [NUM_CH-1:0]       i_stop,
  input  logic [NUM_CH-1:0]       i_pause,
  input  logic [2*NUM_CH-1:0]     i_mode,
  input  logic [NUM_CH*WIDTH-1:0] i_limit,
  output logic [NUM_CH-1:0]       o_busy,
  output logic [NUM_CH-1:0]       o_done,
  output logic [NUM_CH*WIDTH-1:0] o_count,
  output logic                    o_any_done
);

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    duration_channel #(
      .WIDTH(WIDTH)
    ) u_ch (
      .clk   (clk),
      .nRst  (nRst),
      .tick  (i_tick),
      .start (i_start[k]),
      .stop  (i_stop[k]),
      .pause (i_pause[k]),
      .mode  (i_mode[2*k +: 2]),
      .limit (i_limit[WIDTH*k +: WIDTH]),
      .busy  (o_busy[k]),
      .done  (o_done[k]),
      .count (o_count[WIDTH*k +: WIDTH])
    );
  end

  assign o_any_done = |o_done;

endmodule

// File: tb/tb_multi_duration_timer.sv
// Directed bench for multi_duration_timer: a per-cycle vector table on
// channel 0 plus hand-written multi-cycle sequences on the other channels.
module tb_multi_duration_timer;

  localparam int NUM_CH = 4;
  localparam int WIDTH  = 8;

  logic                    clk = 1'b0;
  logic                    nRst;
  logic                    i_tick;
  logic [NUM_CH-1:0]       i_start, i_stop, i_pause;
  logic [2*NUM_CH-1:0]     i_mode;
  logic [NUM_CH*WIDTH-1:0] i_limit;
  logic [NUM_CH-1:0]       o_busy, o_done;
  logic [NUM_CH*WIDTH-1:0] o_count;
  logic                    o_any_done;

  int n_cmp = 0;
  int n_bad = 0;

  multi_duration_timer #(.NUM_CH(NUM_CH), .WIDTH(WIDTH)) dut (
    .clk        (clk),
    .nRst       (nRst),
    .i_tick     (i_tick),
    .i_start    (i_start),
    .i_stop     (i_stop),
    .i_pause    (i_pause),
    .i_mode     (i_mode),
    .i_limit    (i_limit),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_count    (o_count),
    .o_any_done (o_any_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       start, stop, pause, tk;
    logic [1:0] mode;
    logic [7:0] lim;
    logic       e_busy, e_done;
    logic [7:0] e_cnt;
  } vec_t;

  vec_t vt [32];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int cnt_of(input int ch);
    return int'(o_count[WIDTH*ch +: WIDTH]);
  endfunction

  initial begin
    int n;
    int hit;
    int maxc;
    int seen;

    nRst = 1'b1; i_tick = 1'b0; i_start = '0; i_stop = '0; i_pause = '0;
    i_mode = '0; i_limit = '0;
    step(); step(); step();
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_done", int'(o_done), 0);
    chk("rst_count", int'(o_count), 0);
    chk("rst_any", int'(o_any_done), 0);
    nRst = 1'b0;
    step();

    // start stop pause tick mode lim | busy done count
    vt[0]  = '{1'b1,1'b0,1'b0,1'b1,2'd0,8'd5, 1'b1,1'b0,8'd0};
    vt[1]  = '{1'b0,1'b0,1'b0,1'b1,2'd0,8'd5, 1'b1,1'b0,8'd1};
    vt[2]  = '{1'b0,1'b0,1'b0,1'b1,2'd0,8'd5, 1'b1,1'b0,8'd2};
    vt[3]  = '{1'b0,1'b0,1'b0,1'b1,2'd0,8'd5, 1'b1,1'b0,8'd3};
    vt[4]  = '{1'b0,1'b0,1'b0,1'b1,2'd0,8'd5, 1'b1,1'b0,8'd4};
    vt[5]  = '{1'b0,1'b0,1'b0,1'b1,2'd0,8'd5, 1'b0,1'b1,8'd0};
    vt[6]  = '{1'b0,1'b0,1'b0,1'b1,2'd0,8'd5, 1'b0,1'b0,8'd0};
    vt[7]  = '{1'b1,1'b0,1'b0,1'b1,2'd0,8'd0, 1'b0,1'b1,8'd0};
    vt[8]  = '{1'b0,1'b0,1'b0,1'b1,2'd0,8'd0, 1'b0,1'b0,8'd0};
    vt[9]  = '{1'b1,1'b0,1'b0,1'b1,2'd3,8'd2, 1'b1,1'b0,8'd0};
    vt[10] = '{1'b0,1'b0,1'b0,1'b1,2'd3,8'd2, 1'b1,1'b0,8'd1};
    vt[11] = '{1'b0,1'b0,1'b0,1'b1,2'd3,8'd2, 1'b0,1'b1,8'd0};
    vt[12] = '{1'b1,1'b0,1'b0,1'b1,2'd0,8'd2, 1'b1,1'b0,8'd0};
    vt[13] = '{1'b0,1'b0,1'b0,1'b1,2'd0,8'd2, 1'b1,1'b0,8'd1};
    vt[14] = '{1'b1,1'b1,1'b0,1'b1,2'd0,8'd2, 1'b0,1'b0,8'd0};
    vt[15] = '{1'b0,1'b0,1'b0,1'b1,2'd0,8'd2, 1'b0,1'b0,8'd0};
    vt[16] = '{1'b1,1'b0,1'b0,1'b1,2'd0,8'd3, 1'b1,1'b0,8'd0};
    vt[17] = '{1'b0,1'b0,1'b1,1'b1,2'd0,8'd3, 1'b1,1'b0,8'd0};
    vt[18] = '{1'b0,1'b0,1'b0,1'b0,2'd0,8'd3, 1'b1,1'b0,8'd0};
    vt[19] = '{1'b0,1'b0,1'b0,1'b1,2'd0,8'd3, 1'b1,1'b0,8'd1};
    vt[20] = '{1'b0,1'b0,1'b0,1'b1,2'd0,8'd3, 1'b1,1'b0,8'd2};
    vt[21] = '{1'b0,1'b0,1'b0,1'b1,2'd0,8'd3, 1'b0,1'b1,8'd0};
    vt[22] = '{1'b1,1'b0,1'b0,1'b1,2'd0,8'd2, 1'b1,1'b0,8'd0};
    vt[23] = '{1'b0,1'b0,1'b0,1'b1,2'd0,8'd2, 1'b1,1'b0,8'd1};
    vt[24] = '{1'b1,1'b0,1'b0,1'b1,2'd0,8'd3, 1'b1,1'b1,8'd0};
    vt[25] = '{1'b0,1'b0,1'b0,1'b1,2'd0,8'd3, 1'b1,1'b0,8'd1};
    vt[26] = '{1'b0,1'b0,1'b0,1'b1,2'd0,8'd3, 1'b1,1'b0,8'd2};
    vt[27] = '{1'b0,1'b0,1'b0,1'b1,2'd0,8'd3, 1'b0,1'b1,8'd0};
    vt[28] = '{1'b1,1'b0,1'b0,1'b1,2'd2,8'd2, 1'b1,1'b0,8'd0};
    vt[29] = '{1'b1,1'b0,1'b0,1'b1,2'd2,8'd2, 1'b1,1'b0,8'd1};
    vt[30] = '{1'b1,1'b0,1'b0,1'b1,2'd2,8'd2, 1'b0,1'b1,8'd0};
    vt[31] = '{1'b0,1'b0,1'b0,1'b1,2'd2,8'd2, 1'b0,1'b0,8'd0};

    for (int i = 0; i < 32; i++) begin
      i_start[0] = vt[i].start;
      i_stop[0]  = vt[i].stop;
      i_pause[0] = vt[i].pause;
      i_tick     = vt[i].tk;
      i_mode[1:0]  = vt[i].mode;
      i_limit[7:0] = vt[i].lim;
      step();
      chk($sformatf("vec%0d_busy", i), int'(o_busy[0]), int'(vt[i].e_busy));
      chk($sformatf("vec%0d_done", i), int'(o_done[0]), int'(vt[i].e_done));
      chk($sformatf("vec%0d_count", i), cnt_of(0), int'(vt[i].e_cnt));
      chk($sformatf("vec%0d_any", i), int'(o_any_done), int'(vt[i].e_done));
    end
    i_start = '0; i_stop = '0; i_pause = '0;

    // RELOAD on ch1, L=3, tick every second cycle, limit changed mid-run.
    i_tick = 1'b0;
    i_mode[3:2] = 2'b01;
    i_limit[15:8] = 8'd3;
    i_start[1] = 1'b1;
    step();
    i_start[1] = 1'b0;
    chk("rl_start_busy", int'(o_busy[1]), 1);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      i_tick = (i % 2 == 0);
      if (i == 10) i_limit[15:8] = 8'd7;
      step();
      if (i % 2 == 0) n++;
      chk($sformatf("rl%0d_done", i), int'(o_done[1]), int'((i % 2 == 0) && (n % 3 == 0)));
      chk($sformatf("rl%0d_count", i), cnt_of(1), n % 3);
      chk($sformatf("rl%0d_busy", i), int'(o_busy[1]), 1);
    end
    i_stop[1] = 1'b1;
    step();
    i_stop[1] = 1'b0;
    chk("rl_stop_busy", int'(o_busy[1]), 0);

    // LEVEL on ch2, L=10, hold for 6 ticks then drop.
    i_tick = 1'b1;
    i_mode[5:4] = 2'b10;
    i_limit[23:16] = 8'd10;
    i_start[2] = 1'b1;
    step();
    chk("lv_start_busy", int'(o_busy[2]), 1);
    for (int i = 1; i <= 6; i++) begin
      step();
      chk($sformatf("lv%0d_done", i), int'(o_done[2]), 0);
      chk($sformatf("lv%0d_count", i), cnt_of(2), i);
    end
    i_start[2] = 1'b0;
    step();
    chk("lv_drop_busy", int'(o_busy[2]), 0);
    chk("lv_drop_count", cnt_of(2), 0);
    chk("lv_drop_done", int'(o_done[2]), 0);
    step();
    chk("lv_after_done", int'(o_done[2]), 0);

    // Pause on ch3, L=4: two ticks, five paused cycles, then completion.
    i_mode[7:6] = 2'b00;
    i_limit[31:24] = 8'd4;
    i_start[3] = 1'b1;
    step();
    i_start[3] = 1'b0;
    hit = -1;
    for (int k = 1; k <= 30 && hit < 0; k++) begin
      i_pause[3] = (k >= 3 && k <= 7);
      step();
      if (k >= 3 && k <= 7) chk($sformatf("ps%0d_count", k), cnt_of(3), 2);
      if (o_done[3]) hit = k;
    end
    i_pause[3] = 1'b0;
    chk("ps_done_cycle", hit, 9);
    chk("ps_end_busy", int'(o_busy[3]), 0);

    // Maximum limit on ch0: completion after exactly 255 ticks, no wrap.
    i_mode[1:0] = 2'b00;
    i_limit[7:0] = 8'd255;
    i_start[0] = 1'b1;
    step();
    i_start[0] = 1'b0;
    hit = -1;
    maxc = 0;
    for (int k = 1; k <= 300 && hit < 0; k++) begin
      step();
      if (cnt_of(0) > maxc) maxc = cnt_of(0);
      if (o_done[0]) hit = k;
    end
    chk("max_done_cycle", hit, 255);
    chk("max_peak_count", maxc, 254);
    chk("max_end_busy", int'(o_busy[0]), 0);

    // Reset mid-run with all channels active in RELOAD.
    i_mode = {4{2'b01}};
    i_limit = {4{8'd20}};
    i_start = '1;
    step();
    i_start = '0;
    for (int k = 0; k < 5; k++) step();
    chk("mr_busy_pre", int'(o_busy), 15);
    nRst = 1'b1;
    step();
    chk("mr_busy", int'(o_busy), 0);
    chk("mr_done", int'(o_done), 0);
    chk("mr_count", int'(o_count), 0);
    chk("mr_any", int'(o_any_done), 0);
    nRst = 1'b0;
    seen = 0;
    for (int k = 0; k < 30; k++) begin
      step();
      if (o_any_done || o_busy != 0) seen = 1;
    end
    chk("mr_quiet", seen, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
